safety_monitor: RTL
===================

# safety_monitor

Parametrised, multi-channel over-current safety monitor for the motor amplifiers. It sits between the ADC current-feedback path and the amplifier-enable logic. For each channel it compares measured current against commanded (DAC) current, both in offset-binary form. A channel trips only after a violation persists for a configurable number of consecutive samples. Once tripped, the channel's disable stays latched until that channel is explicitly cleared.

## Interface
Parameters:
- NUM_CH, 4, number of motor channels
- WIDTH, 16, sample width in bits (offset binary)
- MID, 2**(WIDTH-1), zero-current code
- DEADBAND, 16'h0300, current magnitude at or below which a sample never violates
- GAIN_SHIFT, 1, violation when mag_cur > (mag_dac << GAIN_SHIFT)
- PERSIST, 8, consecutive violating samples required to trip (1..255)

Ports (reset is synchronous, active-low; clock is clk):
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- cur_in  in  NUM_CH*WIDTH  measured current; channel i at [i*WIDTH +: WIDTH]
- dac_in  in  NUM_CH*WIDTH  commanded current, same packing
- sample_valid  in  NUM_CH  channel i inputs are captured on an edge where bit i=1
- ch_enable  in  NUM_CH  monitoring enable per channel
- fault_clear  in  NUM_CH  single-cycle clear request per channel
- amp_disable  out  NUM_CH  latched trip per channel
- any_fault  out  1  registered OR of amp_disable

## Operation
- Magnitude (stage 1, registered on a valid edge):
  - mag = (x >= MID) ? x - MID : MID - x, kept at WIDTH bits.
  - Sign bit sgn = (x >= MID).
  - The stage-1 valid flag copies sample_valid.
- Violation (stage 2, combinational on stage-1 registers):
  - viol = (mag_cur > DEADBAND) && (sgn_cur == sgn_dac || mag_dac == 0) && (mag_cur > (mag_dac << GAIN_SHIFT)).
  - The shift is evaluated at WIDTH+GAIN_SHIFT bits, with no truncation.
- Per-channel persistence counter, $clog2(PERSIST+1) bits, updated only on edges where stage-1 valid=1:
  - viol=1: cnt <= min(cnt+1, PERSIST).
  - viol=0: cnt <= 0.
- Per-channel trip latch, two states, NORMAL and TRIPPED:
  - NORMAL -> TRIPPED when a valid violating sample drives cnt to PERSIST.
  - TRIPPED -> NORMAL on fault_clear=1; cnt is also reset to 0.
  - Clear and trip on the same edge: trip wins, channel stays TRIPPED.
  - Clear while NORMAL: cnt is zeroed, no other effect.
- Channel disable: ch_enable=0 forces cnt=0, latch=NORMAL and amp_disable=0. Stage-1 registers continue to update.
- Channels are fully independent. sample_valid may differ per channel.

## Timing
- Reset (reset=0 at an edge): all counters 0, latches NORMAL, stage-1 registers 0, amp_disable=0, any_fault=0. Reset overrides every other input, including mid-count.
- Latency: if the PERSIST-th consecutive violating sample is captured at edge k, amp_disable[i]=1 after edge k+1, and any_fault=1 after edge k+2.
- Clear: fault_clear pulse at edge k gives amp_disable[i]=0 after edge k, unless a trip occurs at edge k.
- A sample_valid=0 edge does not break the consecutive run; the counter is held.
- No gaps required between samples. Back-to-back valids on every edge are supported.

## Structure
- Shared package safety_pkg holds: the magnitude function, the counter-width function (clog2), the default DEADBAND/GAIN_SHIFT/PERSIST constants, and a 2-state trip_state_t enum.
- Sub-module safety_channel contains one channel: magnitude stage, violation logic, counter and latch.
- safety_monitor instantiates NUM_CH copies via generate and registers any_fault.

## Test plan
Parameters: WIDTH=16, MID=16'h8000, DEADBAND=16'h0300, GAIN_SHIFT=1, PERSIST=4.
- Deadband: cur=16'h8200, dac=16'h8000, valid on 10 edges -> amp_disable stays 0.
- Positive trip: cur=16'h9000, dac=16'h8400 (mag 0x1000 > 0x800), 4 valids -> amp_disable[0]=1 one edge after the 4th capture. Repeat with 3 violating samples, then cur=16'h8800 -> counter returns to 0, no trip.
- Negative trip and sign: cur=16'h7000, dac=16'h7C00 -> trips after 4 samples. cur=16'h7000, dac=16'h8400 (opposite sign) -> no trip.
- Clear: after a trip, fault_clear pulse -> amp_disable=0 next edge. fault_clear on the same edge as the 4th violation's trip edge -> stays 1.
- Reset mid-operation: reset=0 with cnt=3 -> all outputs 0. One further violating sample after reset -> no trip.
- Mask and independence: ch2 violating with ch_enable[2]=0 -> no trip. ch1 violating with ch_enable[1]=1 -> only amp_disable[1]=1, and any_fault=1 one edge later. Gapped valids (valid every 3rd edge) still trip after 4 samples.

Source files
------------

// File: rtl/safety_pkg.sv
// Shared definitions for the over-current safety monitor.
//   mag_of      : offset-binary magnitude |x - mid| (caller truncates to its width)
//   cnt_width   : bits needed to hold a persistence count 0..persist
//   DEF_*       : default threshold constants
//   trip_state_t: per-channel trip latch state
package safety_pkg;

    localparam int DEF_DEADBAND   = 'h0300;
    localparam int DEF_GAIN_SHIFT = 1;
    localparam int DEF_PERSIST    = 8;

    typedef enum logic [0:0] {
        TRIP_NORMAL  = 1'b0,
        TRIP_TRIPPED = 1'b1
    } trip_state_t;

    // Operands are passed zero-extended to 32 bits so one function serves any WIDTH.
    function automatic logic [31:0] mag_of(input logic [31:0] x, input logic [31:0] mid);
        return (x >= mid) ? (x - mid) : (mid - x);
    endfunction

    function automatic int cnt_width(input int persist);
        return $clog2(persist + 1);
    endfunction

endpackage

// File: rtl/safety_channel.sv
// One over-current monitoring channel.
//   clk, reset          : clock, synchronous active-low reset
//   cur_in, dac_in      : measured / commanded current, offset binary
//   sample_valid        : capture cur_in/dac_in on this edge
//   ch_enable           : 0 holds the channel idle (count 0, latch NORMAL)
//   fault_clear         : clear request for the trip latch
//   state_o             : trip latch state (TRIPPED means amplifier disabled)
// Pipeline: stage 1 registers magnitude/sign of the captured sample; the
// violation test runs combinationally on stage 1 and feeds the persistence
// counter and trip latch on the following edge.
module safety_channel
    import safety_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] MID        = {1'b1, {(WIDTH-1){1'b0}}},
    parameter logic [WIDTH-1:0] DEADBAND   = WIDTH'(DEF_DEADBAND),
    parameter int               GAIN_SHIFT = DEF_GAIN_SHIFT,
    parameter int               PERSIST    = DEF_PERSIST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cur_in,
    input  logic [WIDTH-1:0] dac_in,
    input  logic             sample_valid,
    input  logic             ch_enable,
    input  logic             fault_clear,
    output trip_state_t      state_o
);

    localparam int             CW        = cnt_width(PERSIST);
    localparam int             SW        = WIDTH + GAIN_SHIFT;
    localparam logic [CW-1:0]  PERSIST_C = CW'(PERSIST);
    localparam logic [0:0]     ST_NORMAL  = 1'b0;
    localparam logic [0:0]     ST_TRIPPED = 1'b1;

    logic [WIDTH-1:0] mag_cur_q, mag_cur_d;
    logic [WIDTH-1:0] mag_dac_q, mag_dac_d;
    logic             sgn_cur_q, sgn_cur_d;
    logic             sgn_dac_q, sgn_dac_d;
    logic             vld_q, vld_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [0:0]       state_q, state_d;

    logic [SW-1:0]    dac_scaled;
    logic             viol;
    logic [CW-1:0]    cnt_inc;
    logic             trip_evt;

    // Stage 1: capture on valid; the valid flag itself follows sample_valid every edge.
    always_comb begin
        mag_cur_d = mag_cur_q;
        mag_dac_d = mag_dac_q;
        sgn_cur_d = sgn_cur_q;
        sgn_dac_d = sgn_dac_q;
        vld_d     = sample_valid;
        if (sample_valid) begin
            mag_cur_d = WIDTH'(mag_of(32'(cur_in), 32'(MID)));
            mag_dac_d = WIDTH'(mag_of(32'(dac_in), 32'(MID)));
            sgn_cur_d = (cur_in >= MID);
            sgn_dac_d = (dac_in >= MID);
        end
    end

    // Stage 2: widened compare so the gained DAC magnitude never wraps.
    // A zero command has no meaningful sign, so any direction counts against it.
    always_comb begin
        dac_scaled = SW'(mag_dac_q) << GAIN_SHIFT;
        viol       = (mag_cur_q > DEADBAND)
                  && ((sgn_cur_q == sgn_dac_q) || (mag_dac_q == '0))
                  && (SW'(mag_cur_q) > dac_scaled);
        cnt_inc    = (cnt_q >= PERSIST_C) ? PERSIST_C : (cnt_q + 1'b1);
        trip_evt   = vld_q && viol && (cnt_inc == PERSIST_C);
    end

    // Counter and latch. A trip on the same edge as a clear keeps the latch set.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (vld_q) begin
            cnt_d = viol ? cnt_inc : '0;
        end
        if (trip_evt) begin
            state_d = ST_TRIPPED;
        end else if (fault_clear) begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
        end
        if (!ch_enable) begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mag_cur_q <= '0;
            mag_dac_q <= '0;
            sgn_cur_q <= 1'b0;
            sgn_dac_q <= 1'b0;
            vld_q     <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_NORMAL;
        end else begin
            mag_cur_q <= mag_cur_d;
            mag_dac_q <= mag_dac_d;
            sgn_cur_q <= sgn_cur_d;
            sgn_dac_q <= sgn_dac_d;
            vld_q     <= vld_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
        end
    end

    assign state_o = trip_state_t'(state_q);

endmodule

// File: rtl/safety_monitor.sv
// Multi-channel over-current safety monitor.
//   clk, reset    : clock, synchronous active-low reset
//   cur_in/dac_in : NUM_CH packed samples, channel i at [i*WIDTH +: WIDTH]
//   sample_valid  : per-channel capture strobe
//   ch_enable     : per-channel monitoring enable
//   fault_clear   : per-channel trip clear
//   amp_disable   : per-channel latched trip
//   any_fault     : registered OR of amp_disable (one edge behind it)
module safety_monitor
    import safety_pkg::*;
#(
    parameter int               NUM_CH     = 4,
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] MID        = {1'b1, {(WIDTH-1){1'b0}}},
    parameter logic [WIDTH-1:0] DEADBAND   = WIDTH'(DEF_DEADBAND),
    parameter int               GAIN_SHIFT = DEF_GAIN_SHIFT,
    parameter int               PERSIST    = DEF_PERSIST
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] cur_in,
    input  logic [NUM_CH*WIDTH-1:0] dac_in,
    input  logic [NUM_CH-1:0]       sample_valid,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH-1:0]       fault_clear,
    output logic [NUM_CH-1:0]       amp_disable,
    output logic                    any_fault
);

    trip_state_t ch_state [NUM_CH];
    logic        any_fault_q, any_fault_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        safety_channel #(
            .WIDTH      (WIDTH),
            .MID        (MID),
            .DEADBAND   (DEADBAND),
            .GAIN_SHIFT (GAIN_SHIFT),
            .PERSIST    (PERSIST)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .cur_in       (cur_in[g*WIDTH +: WIDTH]),
            .dac_in       (dac_in[g*WIDTH +: WIDTH]),
            .sample_valid (sample_valid[g]),
            .ch_enable    (ch_enable[g]),
            .fault_clear  (fault_clear[g]),
            .state_o      (ch_state[g])
        );
        assign amp_disable[g] = (ch_state[g] == TRIP_TRIPPED);
    end

    always_comb begin
        any_fault_d = |amp_disable;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            any_fault_q <= 1'b0;
        end else begin
            any_fault_q <= any_fault_d;
        end
    end

    assign any_fault = any_fault_q;

endmodule
